rr_index_arbiter: RTL and testbench
===================================

// Module: rr_index_arbiter
// PURPOSE
//  Round-robin arbiter producing the binary index that feeds the decoderNto2N stage.
//  It takes 2**N request lines and selects one requester fairly.
//  It presents the winner as an N-bit index with a valid/ready handshake.
//  Downstream, decoderNto2N expands grant_idx into the one-hot select.
// PARAMETERS
//  N      3        index width; must match the decoderNto2N N parameter
//  REQ_W  2**N     number of request lines (derived; do not override)
// PORTS
//  clk          in   1      single clock, rising edge
//  rst_n        in   1      asynchronous reset, active-low
//  req          in   REQ_W  request vector; bit i = requester i
//  grant_idx    out  N      winning requester index (binary)
//  grant_valid  out  1      grant_idx is valid
//  grant_ready  in   1      consumer accepts grant this cycle
// BEHAVIOUR
//  Reset values (async, on rst_n low):
//   - grant_idx=0, grant_valid=0, ptr=0, state=IDLE.
//  ptr (N bits) is the highest-priority position for the next search.
//  Arbitration: pick the first set bit of req, scanning ptr, ptr+1, ... REQ_W-1, 0, ...
//   wrapping around. The pick is combinational from req and the search base.
//  FSM IDLE:
//   - if |req: register the pick into grant_idx; grant_valid<=1; go to GRANT.
//   - else stay in IDLE with grant_valid=0.
//   - Latency: req seen at edge t -> grant_valid high after edge t (one cycle).
//  FSM GRANT:
//   - grant_idx and grant_valid are held stable while !grant_ready.
//   - The grant is never retracted, even if req[grant_idx] drops.
//   - On grant_valid && grant_ready: ptr <= grant_idx+1. N-bit natural wrap, so 7 -> 0 at N=3.
//   - Same edge: re-arbitrate with base = grant_idx+1, using current req.
//   - If any req: load the new pick and stay in GRANT (back-to-back, one grant per cycle).
//   - Else: grant_valid<=0 and go to IDLE.
//  Boundary conditions:
//   - A single requester may win on consecutive handshakes; the wrap returns to it.
//   - All REQ_W requesting: strict rotation 0,1,..,REQ_W-1,0.
//   - req changing while stalled has no effect until the handshake.
//   - grant_ready while grant_valid=0 is ignored; ptr is unchanged.
//   - rst_n asserted mid-grant: outputs clear immediately (async); no grant is replayed.
//  Width rules:
//   - Index arithmetic is modulo 2**N; no out-of-range index is possible.
//   - X on req bits is a checker error (assertion).
// STRUCTURE
//  Package arb_pkg:
//   - typedef enum logic {IDLE, GRANT} arb_state_t
//  Sub-module rr_pick (combinational):
//   - inputs req and base; outputs idx and any.
//   - Implemented as a masked/double-width priority encoder.
//  Top: FSM, ptr and output registers.
//  Assertions:
//   - grant_idx/grant_valid stable while grant_valid && !grant_ready.
//   - grant_valid never rises without |req in the prior cycle.
// TESTING (N=3, REQ_W=8, grant_ready=1 unless stated)
//  1. Reset: rst_n=0 mid-run -> grant_valid=0, grant_idx=0 immediately.
//     After release with req=0, IDLE holds.
//  2. req=8'b0000_0100 from IDLE -> grant_idx=2 one cycle later.
//     Next grant is again 2 (ptr=3, wraps back to 2).
//  3. req=8'hFF held -> grant_idx sequence 0,1,2,...,7,0, one per cycle.
//  4. Stall: req=8'b1000_0010, grant_ready=0 for 4 cycles -> grant_idx=1 held.
//     Dropping req[1] keeps grant_idx=1. Then ready=1 -> next grant_idx=7.
//  5. Wrap: after grant 7, req=8'b0000_0011 -> next grant_idx=0, then 1.
//  6. End-to-end with decoderNto2N: each accepted grant_idx=k gives Out=1<<k.
//     Scoreboard checks fairness: no requester waits > REQ_W grants.

Source files
------------

// File: rtl/arb_pkg.sv
// Shared types and sizing helpers for the round-robin index arbiter.
package arb_pkg;

  typedef enum logic {IDLE, GRANT} arb_state_t;

  localparam int ARB_N = 3;

  function automatic int req_width(input int n);
    return 1 << n;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin pick: first set bit of req at or after base, wrapping.
module rr_pick
  import arb_pkg::*;
#(
  parameter int N     = ARB_N,
  parameter int REQ_W = req_width(N)
) (
  input  logic [REQ_W-1:0] req,
  input  logic [N-1:0]     base,
  output logic [N-1:0]     idx,
  output logic             any
);

  logic [REQ_W-1:0] rot;
  logic [N-1:0]     off;
  logic             found;

  // Rotating the doubled vector right by base puts the base position at bit 0,
  // so a plain LSB-first priority encoder yields the offset from base.
  always_comb begin
    rot   = REQ_W'({req, req} >> base);
    off   = '0;
    found = 1'b0;
    for (int i = 0; i < REQ_W; i++) begin
      if (!found && rot[i]) begin
        off   = N'(i);
        found = 1'b1;
      end
    end
    idx = base + off;
  end

  assign any = |req;

endmodule

// File: rtl/rr_index_arbiter.sv
// Round-robin arbiter presenting the winning requester as a binary index
// with a valid/ready handshake.
module rr_index_arbiter
  import arb_pkg::*;
#(
  parameter int N     = ARB_N,
  parameter int REQ_W = req_width(N)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [REQ_W-1:0] req,
  output logic [N-1:0]     grant_idx,
  output logic             grant_valid,
  input  logic             grant_ready
);

  arb_state_t  state;
  logic [N-1:0] ptr;
  logic [N-1:0] pick_base;
  logic [N-1:0] pick_idx;
  logic         pick_any;

  // In GRANT the search starts just past the current winner so a handshake
  // and the next pick happen on the same edge.
  assign pick_base = (state == GRANT) ? grant_idx + N'(1) : ptr;

  rr_pick #(.N(N), .REQ_W(REQ_W)) u_pick (
    .req  (req),
    .base (pick_base),
    .idx  (pick_idx),
    .any  (pick_any)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      grant_idx   <= '0;
      grant_valid <= 1'b0;
      ptr         <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (pick_any) begin
            grant_idx   <= pick_idx;
            grant_valid <= 1'b1;
            state       <= GRANT;
          end else begin
            grant_valid <= 1'b0;
          end
        end
        GRANT: begin
          if (grant_ready) begin
            ptr <= grant_idx + N'(1);
            if (pick_any) begin
              grant_idx <= pick_idx;
            end else begin
              grant_valid <= 1'b0;
              state       <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  a_hold_stable: assert property (@(posedge clk) disable iff (!rst_n)
    grant_valid && !grant_ready |=> grant_valid && $stable(grant_idx));

  a_rise_needs_req: assert property (@(posedge clk) disable iff (!rst_n)
    $rose(grant_valid) |-> $past(|req));

  a_req_known: assert property (@(posedge clk) disable iff (!rst_n)
    !$isunknown(req));

endmodule

// File: tb/tb_rr_index_arbiter.sv
// Directed and model-checked bench for rr_index_arbiter at N=3.
module tb_rr_index_arbiter;

  logic       clk;
  logic       rst_n;
  logic [7:0] req;
  logic [2:0] grant_idx;
  logic       grant_valid;
  logic       grant_ready;

  int tests;
  int fails;

  rr_index_arbiter #(.N(3)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req         (req),
    .grant_idx   (grant_idx),
    .grant_valid (grant_valid),
    .grant_ready (grant_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [2:0] scan(input logic [7:0] r, input logic [2:0] b);
    for (int k = 0; k < 8; k++) begin
      if (r[(int'(b) + k) % 8]) return 3'((int'(b) + k) % 8);
    end
    return 3'd0;
  endfunction

  logic       mv;
  logic [2:0] mi;
  logic [2:0] mp;
  logic [7:0] held;
  logic       rdy;
  logic       acc;
  logic [2:0] acc_idx;
  int         waits [8];
  int         max_wait;

  initial begin
    tests = 0;
    fails = 0;
    rst_n = 1'b0;
    req = '0;
    grant_ready = 1'b1;
    tick();
    tick();
    rst_n = 1'b1;
    check("reset_valid", 32'(grant_valid), 32'd0);
    check("reset_idx", 32'(grant_idx), 32'd0);
    tick();
    tick();
    check("idle_hold", 32'(grant_valid), 32'd0);

    // single requester wins, then wins again through the wrap
    req = 8'b0000_0100;
    tick();
    check("single_first_valid", 32'(grant_valid), 32'd1);
    check("single_first_idx", 32'(grant_idx), 32'd2);
    tick();
    check("single_again_idx", 32'(grant_idx), 32'd2);
    req = 8'h00;
    tick();
    check("single_drop_valid", 32'(grant_valid), 32'd0);

    // ready while idle must not move ptr (left at 3)
    tick();
    tick();
    check("ready_idle_valid", 32'(grant_valid), 32'd0);
    req = 8'b0001_0100;
    tick();
    check("ptr_kept_idx", 32'(grant_idx), 32'd4);
    req = 8'h00;
    tick();
    check("ptr_kept_drop", 32'(grant_valid), 32'd0);

    // mid-grant async reset clears outputs without waiting for an edge
    req = 8'hFF;
    tick();
    check("pre_reset_idx", 32'(grant_idx), 32'd5);
    #2 rst_n = 1'b0;
    #1;
    check("async_reset_valid", 32'(grant_valid), 32'd0);
    check("async_reset_idx", 32'(grant_idx), 32'd0);
    tick();
    rst_n = 1'b1;

    // all requesting: strict rotation from 0
    for (int k = 0; k < 9; k++) begin
      tick();
      check("rotate_idx", 32'(grant_idx), 32'(k % 8));
    end

    // stall holds the grant even when its request drops
    req = 8'b1000_0010;
    tick();
    check("stall_first_idx", 32'(grant_idx), 32'd1);
    grant_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      tick();
      check("stall_hold_idx", 32'(grant_idx), 32'd1);
      check("stall_hold_valid", 32'(grant_valid), 32'd1);
    end
    req = 8'b1000_0000;
    tick();
    check("stall_dropped_idx", 32'(grant_idx), 32'd1);
    grant_ready = 1'b1;
    tick();
    check("stall_release_idx", 32'(grant_idx), 32'd7);

    // wrap past 7 back to 0
    req = 8'b0000_0011;
    tick();
    check("wrap_idx0", 32'(grant_idx), 32'd0);
    tick();
    check("wrap_idx1", 32'(grant_idx), 32'd1);
    req = 8'h00;
    tick();
    check("wrap_end_valid", 32'(grant_valid), 32'd0);

    // randomised traffic against a reference model; requesters hold until served
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    mv = 1'b0;
    mi = '0;
    mp = '0;
    held = '0;
    max_wait = 0;
    for (int j = 0; j < 8; j++) waits[j] = 0;
    for (int c = 0; c < 400; c++) begin
      rdy = ($urandom_range(3) != 0);
      grant_ready = rdy;
      req = held;
      acc = mv && rdy;
      acc_idx = mi;
      if (!mv) begin
        if (|held) begin
          mi = scan(held, mp);
          mv = 1'b1;
        end
      end else if (rdy) begin
        mp = mi + 3'd1;
        if (|held) mi = scan(held, mi + 3'd1);
        else mv = 1'b0;
      end
      tick();
      check("model_valid", 32'(grant_valid), 32'(mv));
      if (mv) check("model_idx", 32'(grant_idx), 32'(mi));
      if (acc) begin
        for (int j = 0; j < 8; j++) begin
          if (j == int'(acc_idx)) waits[j] = 0;
          else if (held[j]) waits[j]++;
          if (waits[j] > max_wait) max_wait = waits[j];
        end
        held[acc_idx] = 1'b0;
      end
      for (int j = 0; j < 8; j++) begin
        if (!held[j] && $urandom_range(3) == 0) held[j] = 1'b1;
      end
    end
    check("fair_max_wait_le_8", 32'(max_wait <= 8), 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
